// File: rtl/dbgtrig.sv
// Trigger qualifier feeding dbgprobe: masked compare, hit counting, post-trigger delay, sticky trigger.
// Optional edge-qualified hits are enabled by defining DBGTRIG_EDGE_EN (adds edge_i).
module dbgtrig #(
   parameter int unsigned PROBEWIDTH = 32,
   parameter int unsigned CNTWIDTH   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  arm_i,
   input  logic                  disarm_i,
   input  logic [PROBEWIDTH-1:0] value_i,
   input  logic [PROBEWIDTH-1:0] mask_i,
   input  logic [CNTWIDTH-1:0]   count_i,
   input  logic [CNTWIDTH-1:0]   delay_i,
   input  logic [PROBEWIDTH-1:0] probe_i,
`ifdef DBGTRIG_EDGE_EN
   input  logic                  edge_i,
`endif
   output logic [PROBEWIDTH-1:0] probe_o,
   output logic                  trig_o,
   output logic [1:0]            state_o,
   output logic [CNTWIDTH-1:0]   cnt_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] DELAY = 2'd2;
   localparam logic [1:0] FIRED = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  trig_q, trig_d;
   logic [PROBEWIDTH-1:0] probe_q, probe_d;
   logic [PROBEWIDTH-1:0] value_q, value_d;
   logic [PROBEWIDTH-1:0] mask_q, mask_d;
   logic [CNTWIDTH-1:0]   delay_q, delay_d;
   logic [CNTWIDTH-1:0]   cnt_q, cnt_d;
   logic                  match;
   logic                  hit;
`ifdef DBGTRIG_EDGE_EN
   logic                  edge_q, edge_d;
   logic                  match_q, match_d;
`endif

   // Single counter: remaining hits in ARMED, remaining delay in DELAY, zero elsewhere.
   always_comb begin
      state_d = state_q;
      trig_d  = trig_q;
      probe_d = probe_i;
      value_d = value_q;
      mask_d  = mask_q;
      delay_d = delay_q;
      cnt_d   = cnt_q;
      match   = (((probe_i ^ value_q) & mask_q) == '0);
`ifdef DBGTRIG_EDGE_EN
      edge_d  = edge_q;
      match_d = match_q;
      hit     = edge_q ? (match && !match_q) : match;
`else
      hit     = match;
`endif

      case (state_q)
         IDLE: begin
            trig_d = 1'b0;
            if (arm_i && !disarm_i) begin
               value_d = value_i;
               mask_d  = mask_i;
               delay_d = delay_i;
               cnt_d   = (count_i == '0) ? CNTWIDTH'(1) : count_i;
`ifdef DBGTRIG_EDGE_EN
               edge_d  = edge_i;
               match_d = 1'b0;
`endif
               state_d = ARMED;
            end
         end
         ARMED: begin
`ifdef DBGTRIG_EDGE_EN
            match_d = match;
`endif
            if (hit) begin
               if (cnt_q <= CNTWIDTH'(1)) begin
                  if (delay_q == '0) begin
                     state_d = FIRED;
                     trig_d  = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     state_d = DELAY;
                     cnt_d   = delay_q;
                  end
               end else begin
                  cnt_d = cnt_q - CNTWIDTH'(1);
               end
            end
         end
         DELAY: begin
            if (cnt_q <= CNTWIDTH'(1)) begin
               state_d = FIRED;
               trig_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNTWIDTH'(1);
            end
         end
         FIRED: begin
            trig_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            trig_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase

      // Disarm overrides everything, including a simultaneous arm.
      if (disarm_i) begin
         state_d = IDLE;
         trig_d  = 1'b0;
         cnt_d   = '0;
`ifdef DBGTRIG_EDGE_EN
         match_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         trig_q  <= 1'b0;
         probe_q <= '0;
         value_q <= '0;
         mask_q  <= '0;
         delay_q <= '0;
         cnt_q   <= '0;
`ifdef DBGTRIG_EDGE_EN
         edge_q  <= 1'b0;
         match_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         trig_q  <= trig_d;
         probe_q <= probe_d;
         value_q <= value_d;
         mask_q  <= mask_d;
         delay_q <= delay_d;
         cnt_q   <= cnt_d;
`ifdef DBGTRIG_EDGE_EN
         edge_q  <= edge_d;
         match_q <= match_d;
`endif
      end
   end

   assign probe_o = probe_q;
   assign trig_o  = trig_q;
   assign state_o = state_q;
   assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_dbgtrig.sv
// Directed bench for dbgtrig: per-cycle expectations are queued with the stimulus and checked after each edge.
module tb_dbgtrig;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        arm_i;
   logic        disarm_i;
   logic [31:0] value_i;
   logic [31:0] mask_i;
   logic [15:0] count_i;
   logic [15:0] delay_i;
   logic [31:0] probe_i;
   logic        edge_i;
   logic [31:0] probe_o;
   logic        trig_o;
   logic [1:0]  state_o;
   logic [15:0] cnt_o;

   typedef struct {
      logic [1:0]  st;
      logic        trig;
      logic [15:0] cnt;
      logic [31:0] probe;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk_i = ~clk_i;

   dbgtrig dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .arm_i   (arm_i),
      .disarm_i(disarm_i),
      .value_i (value_i),
      .mask_i  (mask_i),
      .count_i (count_i),
      .delay_i (delay_i),
      .probe_i (probe_i),
`ifdef DBGTRIG_EDGE_EN
      .edge_i  (edge_i),
`endif
      .probe_o (probe_o),
      .trig_o  (trig_o),
      .state_o (state_o),
      .cnt_o   (cnt_o)
   );

   task automatic push_exp(input string tag, input logic [1:0] st, input logic tr,
                           input logic [15:0] cn, input logic [31:0] pr);
      exp_t e;
      e.st = st; e.trig = tr; e.cnt = cn; e.probe = pr;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_pop();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (state_o === e.st) else begin
         errors++;
         $error("FAIL %s state_o observed=%0d expected=%0d", t, state_o, e.st);
      end
      checks++;
      assert (trig_o === e.trig) else begin
         errors++;
         $error("FAIL %s trig_o observed=%0b expected=%0b", t, trig_o, e.trig);
      end
      checks++;
      assert (cnt_o === e.cnt) else begin
         errors++;
         $error("FAIL %s cnt_o observed=%0d expected=%0d", t, cnt_o, e.cnt);
      end
      checks++;
      assert (probe_o === e.probe) else begin
         errors++;
         $error("FAIL %s probe_o observed=%h expected=%h", t, probe_o, e.probe);
      end
   endtask

   // Queue the expected post-edge outputs for the current inputs, clock once, then compare.
   task automatic cyc(input string tag, input logic [1:0] st, input logic tr, input logic [15:0] cn);
      push_exp(tag, st, tr, cn, probe_i);
      @(posedge clk_i);
      #1;
      check_pop();
   endtask

   task automatic arm_cfg(input logic [31:0] v, input logic [31:0] m, input logic [15:0] c,
                          input logic [15:0] d);
      value_i = v; mask_i = m; count_i = c; delay_i = d; arm_i = 1'b1;
   endtask

   initial begin
      rst_i = 1'b0; arm_i = 1'b0; disarm_i = 1'b0; value_i = '0; mask_i = '0;
      count_i = '0; delay_i = '0; probe_i = 32'hA5A5_A5A5; edge_i = 1'b0;
      #3;
      push_exp("reset", 2'd0, 1'b0, 16'd0, 32'd0);
      check_pop();
      @(posedge clk_i); #1;
      rst_i = 1'b1;

      // Full-width exact match, count 1, no delay.
      arm_cfg(32'h1234_5678, 32'hFFFF_FFFF, 16'd1, 16'd0); probe_i = 32'h0;
      cyc("arm1", 2'd1, 1'b0, 16'd1);
      arm_i = 1'b0; probe_i = 32'h1111_1111;
      cyc("nomatch1", 2'd1, 1'b0, 16'd1);
      probe_i = 32'h1234_5678;
      cyc("fire1", 2'd3, 1'b1, 16'd0);
      probe_i = 32'h0000_DEAD;
      cyc("fired_hold", 2'd3, 1'b1, 16'd0);

      // Arm ignored in FIRED; disarm beats arm; arm alone relatches.
      arm_cfg(32'h0, 32'h0, 16'd1, 16'd0);
      cyc("arm_in_fired", 2'd3, 1'b1, 16'd0);
      disarm_i = 1'b1;
      cyc("disarm_arm", 2'd0, 1'b0, 16'd0);
      disarm_i = 1'b0;
      arm_cfg(32'h0000_CAFE, 32'hFFFF_FFFF, 16'd1, 16'd0); probe_i = 32'h1234_5678;
      cyc("rearm", 2'd1, 1'b0, 16'd1);
      arm_i = 1'b0;
      cyc("old_value", 2'd1, 1'b0, 16'd1);
      probe_i = 32'h0000_CAFE;
      cyc("new_value", 2'd3, 1'b1, 16'd0);
      disarm_i = 1'b1;
      cyc("disarm", 2'd0, 1'b0, 16'd0);
      disarm_i = 1'b0;

      // Low-byte mask, three non-consecutive hits.
      arm_cfg(32'h0000_00AB, 32'h0000_00FF, 16'd3, 16'd0); probe_i = 32'h0;
      cyc("arm3", 2'd1, 1'b0, 16'd3);
      arm_i = 1'b0; probe_i = 32'h0000_11AB;
      cyc("hit3a", 2'd1, 1'b0, 16'd2);
      probe_i = 32'h0000_00AC;
      cyc("miss3", 2'd1, 1'b0, 16'd2);
      probe_i = 32'hFFFF_FFAB;
      cyc("hit3b", 2'd1, 1'b0, 16'd1);
      probe_i = 32'h0000_0012;
      cyc("miss3b", 2'd1, 1'b0, 16'd1);
      probe_i = 32'h0000_55AB;
      cyc("hit3c", 2'd3, 1'b1, 16'd0);
      disarm_i = 1'b1;
      cyc("disarm3", 2'd0, 1'b0, 16'd0);
      disarm_i = 1'b0;

      // count 0 acts as 1; mask 0 matches on the first armed cycle.
      arm_cfg(32'h1357_9BDF, 32'h0, 16'd0, 16'd0); probe_i = 32'h0000_0001;
      cyc("arm_cnt0", 2'd1, 1'b0, 16'd1);
      arm_i = 1'b0; probe_i = 32'h0F0F_0F0F;
      cyc("mask0_fire", 2'd3, 1'b1, 16'd0);
      disarm_i = 1'b1;
      cyc("disarm0", 2'd0, 1'b0, 16'd0);
      disarm_i = 1'b0;

      // Delay of 5 after a single hit.
      arm_cfg(32'h5, 32'hFFFF_FFFF, 16'd1, 16'd5); probe_i = 32'h0;
      cyc("arm_d5", 2'd1, 1'b0, 16'd1);
      arm_i = 1'b0; probe_i = 32'h5;
      cyc("hit_d5", 2'd2, 1'b0, 16'd5);
      probe_i = 32'h0;
      cyc("dly4", 2'd2, 1'b0, 16'd4);
      cyc("dly3", 2'd2, 1'b0, 16'd3);
      cyc("dly2", 2'd2, 1'b0, 16'd2);
      cyc("dly1", 2'd2, 1'b0, 16'd1);
      cyc("dly_fire", 2'd3, 1'b1, 16'd0);
      disarm_i = 1'b1;
      cyc("disarm_d", 2'd0, 1'b0, 16'd0);
      disarm_i = 1'b0;

      // Asynchronous reset while in DELAY with cnt 3.
      arm_cfg(32'h5, 32'hFFFF_FFFF, 16'd1, 16'd5); probe_i = 32'h0;
      cyc("arm_r", 2'd1, 1'b0, 16'd1);
      arm_i = 1'b0; probe_i = 32'h5;
      cyc("hit_r", 2'd2, 1'b0, 16'd5);
      cyc("dly_r4", 2'd2, 1'b0, 16'd4);
      cyc("dly_r3", 2'd2, 1'b0, 16'd3);
      #2 rst_i = 1'b0;
      #1;
      push_exp("async_reset", 2'd0, 1'b0, 16'd0, 32'd0);
      check_pop();
      @(posedge clk_i); #1;
      rst_i = 1'b1;

      // Maximum count latched without truncation.
      arm_cfg(32'h0000_0042, 32'h0000_00FF, 16'hFFFF, 16'd0); probe_i = 32'h0;
      cyc("arm_max", 2'd1, 1'b0, 16'hFFFF);
      arm_i = 1'b0; probe_i = 32'h0000_0042;
      cyc("hit_max", 2'd1, 1'b0, 16'hFFFE);
      disarm_i = 1'b1;
      cyc("disarm_max", 2'd0, 1'b0, 16'd0);
      disarm_i = 1'b0;

`ifdef DBGTRIG_EDGE_EN
      // Edge mode: a held match counts once.
      edge_i = 1'b1;
      arm_cfg(32'h77, 32'hFFFF_FFFF, 16'd2, 16'd0); probe_i = 32'h0;
      cyc("arm_edge", 2'd1, 1'b0, 16'd2);
      arm_i = 1'b0; edge_i = 1'b0; probe_i = 32'h77;
      cyc("edge_first", 2'd1, 1'b0, 16'd1);
      for (int i = 0; i < 9; i++) cyc("edge_held", 2'd1, 1'b0, 16'd1);
      probe_i = 32'h0;
      cyc("edge_gap", 2'd1, 1'b0, 16'd1);
      probe_i = 32'h77;
      cyc("edge_fire", 2'd3, 1'b1, 16'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
